// File: rtl/noc_ni_local.sv
// rtl/noc_ni_local.sv - local network interface: PE injection queue, router ejection unpack, latency and traffic stats
module noc_ni_local #(
    parameter int         DATASIZE = 40,
    parameter int         DEPTH    = 4,
    parameter logic [3:0] NODE_ID  = 4'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pe_valid,
    input  logic [3:0]          pe_dst,
    input  logic [21:0]         pe_data,
    input  logic [1:0]          pe_type,
    output logic                pe_ready,
    output logic [DATASIZE-1:0] inj_data,
    output logic                inj_valid,
    input  logic                router_full,
    input  logic [DATASIZE-1:0] ej_data,
    input  logic                ej_valid,
    output logic                rx_valid,
    output logic [3:0]          rx_src,
    output logic [21:0]         rx_data,
    output logic [1:0]          rx_type,
    output logic [7:0]          rx_latency,
    output logic [7:0]          now_ts,
    output logic [15:0]         tx_count,
    output logic [15:0]         rx_count,
    output logic [15:0]         misroute_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATASIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic [7:0]          r_now_ts;
    logic [DATASIZE-1:0] r_inj_data;
    logic                r_inj_valid;
    logic                r_rx_valid;
    logic [3:0]          r_rx_src;
    logic [21:0]         r_rx_data;
    logic [1:0]          r_rx_type;
    logic [7:0]          r_rx_latency;
    logic [15:0]         r_tx_count;
    logic [15:0]         r_rx_count;
    logic [15:0]         r_mis_count;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_ej_local;

    // Ready depends on registered count only, so a same-cycle pop never frees a slot.
    assign w_ready    = (r_count < CW'(DEPTH));
    assign w_push     = pe_valid && w_ready;
    assign w_pop      = (r_count != '0) && !router_full;
    assign w_ej_local = (ej_data[35:32] == NODE_ID);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {NODE_ID, pe_dst, r_now_ts, pe_data, pe_type};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_now_ts     <= '0;
            r_inj_data   <= '0;
            r_inj_valid  <= 1'b0;
            r_rx_valid   <= 1'b0;
            r_rx_src     <= '0;
            r_rx_data    <= '0;
            r_rx_type    <= '0;
            r_rx_latency <= '0;
            r_tx_count   <= '0;
            r_rx_count   <= '0;
            r_mis_count  <= '0;
        end else begin
            r_now_ts    <= r_now_ts + 8'd1;
            r_inj_valid <= w_pop;
            r_rx_valid  <= 1'b0;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_inj_data <= r_mem[r_rptr];
                r_rptr     <= r_rptr + 1'b1;
                if (r_tx_count != 16'hFFFF) r_tx_count <= r_tx_count + 16'd1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (ej_valid) begin
                if (w_ej_local) begin
                    r_rx_valid   <= 1'b1;
                    r_rx_src     <= ej_data[39:36];
                    r_rx_data    <= ej_data[23:2];
                    r_rx_type    <= ej_data[1:0];
                    r_rx_latency <= r_now_ts - ej_data[31:24];
                    if (r_rx_count != 16'hFFFF) r_rx_count <= r_rx_count + 16'd1;
                end else begin
                    if (r_mis_count != 16'hFFFF) r_mis_count <= r_mis_count + 16'd1;
                end
            end
        end
    end

    assign pe_ready       = w_ready;
    assign inj_data       = r_inj_data;
    assign inj_valid      = r_inj_valid;
    assign rx_valid       = r_rx_valid;
    assign rx_src         = r_rx_src;
    assign rx_data        = r_rx_data;
    assign rx_type        = r_rx_type;
    assign rx_latency     = r_rx_latency;
    assign now_ts         = r_now_ts;
    assign tx_count       = r_tx_count;
    assign rx_count       = r_rx_count;
    assign misroute_count = r_mis_count;
endmodule

// File: tb/tb_noc_ni_local.sv
// tb/tb_noc_ni_local.sv - scoreboard bench for noc_ni_local with NODE_ID=5, DEPTH=4
module tb_noc_ni_local;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pe_valid;
    logic [3:0]  pe_dst;
    logic [21:0] pe_data;
    logic [1:0]  pe_type;
    logic        pe_ready;
    logic [39:0] inj_data;
    logic        inj_valid;
    logic        router_full;
    logic [39:0] ej_data;
    logic        ej_valid;
    logic        rx_valid;
    logic [3:0]  rx_src;
    logic [21:0] rx_data;
    logic [1:0]  rx_type;
    logic [7:0]  rx_latency;
    logic [7:0]  now_ts;
    logic [15:0] tx_count;
    logic [15:0] rx_count;
    logic [15:0] misroute_count;

    int total = 0;
    int bad   = 0;
    logic [39:0] exp_inj [$];
    logic [35:0] exp_rx  [$];
    int inj_pulses = 0;

    noc_ni_local #(.DATASIZE(40), .DEPTH(4), .NODE_ID(4'h5)) dut (
        .clk(clk), .rst_n(rst_n),
        .pe_valid(pe_valid), .pe_dst(pe_dst), .pe_data(pe_data), .pe_type(pe_type),
        .pe_ready(pe_ready), .inj_data(inj_data), .inj_valid(inj_valid),
        .router_full(router_full), .ej_data(ej_data), .ej_valid(ej_valid),
        .rx_valid(rx_valid), .rx_src(rx_src), .rx_data(rx_data), .rx_type(rx_type),
        .rx_latency(rx_latency), .now_ts(now_ts), .tx_count(tx_count),
        .rx_count(rx_count), .misroute_count(misroute_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT strobes an output.
    always @(negedge clk) begin
        if (rst_n && inj_valid) begin
            inj_pulses++;
            if (exp_inj.size() == 0) begin
                chk("inj_unexpected", 40'd1, 40'd0);
            end else begin
                chk("inj_data", inj_data, exp_inj.pop_front());
            end
        end
        if (rst_n && rx_valid) begin
            if (exp_rx.size() == 0) begin
                chk("rx_unexpected", 40'd1, 40'd0);
            end else begin
                chk("rx_fields", {4'h0, rx_src, rx_data, rx_type, rx_latency}, {4'h0, exp_rx.pop_front()});
            end
        end
    end

    task automatic push(input logic [3:0] dst, input logic [21:0] data, input logic [1:0] typ);
        int n = 0;
        pe_valid = 1'b1;
        pe_dst   = dst;
        pe_data  = data;
        pe_type  = typ;
        while (!pe_ready && n < 50) begin
            tick();
            n++;
        end
        if (!pe_ready) chk("push_timeout", 40'd1, 40'd0);
        else exp_inj.push_back({4'h5, dst, now_ts, data, typ});
        tick();
        pe_valid = 1'b0;
    endtask

    task automatic wait_ts(input logic [7:0] ts);
        int n = 0;
        while (now_ts != ts && n < 300) begin
            tick();
            n++;
        end
        if (now_ts != ts) chk("ts_timeout", {32'd0, now_ts}, {32'd0, ts});
    endtask

    task automatic eject(input logic [3:0] src, input logic [3:0] dst, input logic [7:0] ts,
                         input logic [21:0] data, input logic [1:0] typ);
        ej_valid = 1'b1;
        ej_data  = {src, dst, ts, data, typ};
        if (dst == 4'h5) exp_rx.push_back({src, data, typ, 8'(now_ts - ts)});
        tick();
        ej_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_inj.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", 40'(exp_inj.size()), 40'd0);
    endtask

    initial begin
        rst_n = 1'b0; pe_valid = 1'b0; pe_dst = '0; pe_data = '0; pe_type = '0;
        router_full = 1'b0; ej_valid = 1'b0; ej_data = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_inj_valid", {39'd0, inj_valid}, 40'd0);
        chk("rst_inj_data", inj_data, 40'd0);
        chk("rst_pe_ready", {39'd0, pe_ready}, 40'd1);
        chk("rst_now_ts", {32'd0, now_ts}, 40'd0);
        chk("rst_counters", {tx_count, rx_count, misroute_count[7:0]}, 40'd0);
        chk("rst_rx", {rx_valid, rx_src, rx_data, rx_type, rx_latency}, 40'd0);

        // Single injection at now_ts=7.
        wait_ts(8'd7);
        push(4'h3, 22'h1ABCD, 2'b10);
        chk("inj_latency_early", {39'd0, inj_valid}, 40'd0);
        tick();
        chk("inj_valid_1", {39'd0, inj_valid}, 40'd1);
        chk("inj_data_1", inj_data, 40'h530706AF36);
        chk("tx_count_1", {24'd0, tx_count}, 40'd1);

        // Fill queue under back-pressure, then release.
        router_full = 1'b1;
        push(4'h1, 22'h00011, 2'b01);
        push(4'h2, 22'h00022, 2'b10);
        push(4'h3, 22'h00033, 2'b11);
        push(4'h4, 22'h00044, 2'b00);
        pe_valid = 1'b1; pe_dst = 4'h6; pe_data = 22'h00055; pe_type = 2'b01;
        chk("full_pe_ready", {39'd0, pe_ready}, 40'd0);
        tick();
        chk("full_inj_valid", {39'd0, inj_valid}, 40'd0);
        chk("full_pe_ready_2", {39'd0, pe_ready}, 40'd0);
        inj_pulses = 0;
        router_full = 1'b0;
        chk("pop_cycle_pe_ready", {39'd0, pe_ready}, 40'd0);
        push(4'h6, 22'h00055, 2'b01);
        drain();
        tick();
        chk("burst_pulses", 40'(inj_pulses), 40'd5);
        chk("tx_count_6", {24'd0, tx_count}, 40'd6);

        // Local ejection with wrapped latency, then back-to-back.
        wait_ts(8'h10);
        eject(4'h9, 4'h5, 8'hF0, 22'h2AAAA, 2'b11);
        chk("rx_valid_1", {39'd0, rx_valid}, 40'd1);
        chk("rx_src_1", {36'd0, rx_src}, 40'd9);
        chk("rx_latency_1", {32'd0, rx_latency}, 40'h20);
        chk("rx_count_1", {24'd0, rx_count}, 40'd1);
        tick();
        chk("rx_pulse_end", {39'd0, rx_valid}, 40'd0);
        eject(4'h1, 4'h5, 8'h00, 22'h12345, 2'b01);
        eject(4'hC, 4'h5, 8'hFF, 22'h3FFFF, 2'b10);
        chk("rx_b2b", {39'd0, rx_valid}, 40'd1);
        tick();
        chk("rx_count_3", {24'd0, rx_count}, 40'd3);

        // Misrouted flit leaves rx fields untouched.
        eject(4'h7, 4'h2, 8'h11, 22'h0BEEF, 2'b00);
        chk("mis_rx_valid", {39'd0, rx_valid}, 40'd0);
        chk("mis_count", {24'd0, misroute_count}, 40'd1);
        chk("mis_rx_hold", {4'h0, rx_src, rx_data, rx_type, 8'h00}, {4'h0, 4'hC, 22'h3FFFF, 2'b10, 8'h00});

        // Reset with queued flits and an ejection in the reset cycle.
        router_full = 1'b1;
        push(4'h1, 22'h00001, 2'b00);
        push(4'h2, 22'h00002, 2'b00);
        push(4'h3, 22'h00003, 2'b00);
        chk("pre_rst_pe_ready", {39'd0, pe_ready}, 40'd1);
        rst_n = 1'b0;
        ej_valid = 1'b1; ej_data = {4'h3, 4'h5, 8'h00, 22'h00077, 2'b00};
        tick();
        rst_n = 1'b1; ej_valid = 1'b0;
        exp_inj.delete();
        router_full = 1'b0;
        chk("mrst_inj_valid", {39'd0, inj_valid}, 40'd0);
        chk("mrst_pe_ready", {39'd0, pe_ready}, 40'd1);
        chk("mrst_counters", {tx_count, rx_count, misroute_count[7:0]}, 40'd0);
        chk("mrst_mis_hi", {32'd0, misroute_count[15:8]}, 40'd0);
        chk("mrst_rx_valid", {39'd0, rx_valid}, 40'd0);
        inj_pulses = 0;
        tick(); tick(); tick();
        chk("mrst_no_issue", 40'(inj_pulses), 40'd0);
        chk("rx_left", 40'(exp_rx.size()), 40'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
